// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked dual-port data RAM.
package ram_pkg;

    localparam int LANE_W = 8;

    typedef enum logic {
        RAM_INIT,
        RAM_RUN
    } ram_state_t;

    function automatic logic [LANE_W-1:0] lane_merge(
        input logic [LANE_W-1:0] old_lane,
        input logic [LANE_W-1:0] new_lane,
        input logic              sel
    );
        return sel ? new_lane : old_lane;
    endfunction

endpackage

// File: rtl/ram_banked_dp_lane.sv
// One byte-wide bank: a single write port and two enabled synchronous read ports.
module ram_lane #(
    parameter int DEPTH = 2048,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       din,
    input  logic             rd_en_a,
    input  logic [IDX_W-1:0] rd_idx_a,
    input  logic             rd_en_b,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [7:0]       dout_a,
    output logic [7:0]       dout_b
);

    logic [7:0] mem [DEPTH];
    logic [7:0] dout_a_q;
    logic [7:0] dout_b_q;

    // Reads see the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= din;
        end
        if (rd_en_a) begin
            dout_a_q <= mem[rd_idx_a];
        end
        if (rd_en_b) begin
            dout_b_q <= mem[rd_idx_b];
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule

// File: rtl/ram_banked_dp.sv
// Byte-lane data RAM with a CPU load/store port, a read-only video port and a zeroing init sweep.
// Define RAM_WR_BYPASS_EN to forward a same-cycle CPU write onto a colliding video read.
module ram_banked_dp
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 32,
    localparam int LANES = DATA_W / LANE_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LANES-1:0]  sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid
);

    ram_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;
    logic             rd_zero_q, rd_zero_d;
    logic             vid_valid_q, vid_valid_d;
    logic             vid_zero_q, vid_zero_d;

    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  vid_idx;
    logic              cpu_oor;
    logic              vid_oor;
    logic              cpu_acc;
    logic [LANES-1:0]  lane_wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_din;
    logic              rd_en_a;
    logic              rd_en_b;
    logic [DATA_W-1:0] lane_a_word;
    logic [DATA_W-1:0] lane_b_word;
    logic [DATA_W-1:0] vid_word;

    assign ready   = (state_q == RAM_RUN);
    assign cpu_idx = addr[IDX_W+1:2];
    assign vid_idx = vid_addr[IDX_W+1:2];
    assign cpu_oor = |(addr >> (IDX_W + 2));
    assign vid_oor = |(vid_addr >> (IDX_W + 2));
    assign cpu_acc = ready & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RAM_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RAM_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RAM_RUN;
                end
            end
            RAM_RUN: begin
                state_d = RAM_RUN;
            end
            default: begin
                state_d = RAM_INIT;
            end
        endcase
    end

    // The sweep owns the write port until RUN; afterwards only in-range CPU writes reach it.
    always_comb begin
        lane_wr_en = '0;
        wr_idx     = cpu_idx;
        wr_din     = wdata;
        if (state_q == RAM_INIT) begin
            lane_wr_en = '1;
            wr_idx     = cnt_q;
            wr_din     = '0;
        end else if (cpu_acc && we && !cpu_oor) begin
            lane_wr_en = sel;
        end
        rd_en_a = cpu_acc & ~we & ~cpu_oor;
        rd_en_b = vid_req & ready & ~vid_oor;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ram_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk      (clk),
            .wr_en    (lane_wr_en[i]),
            .idx      (wr_idx),
            .din      (wr_din[i*LANE_W +: LANE_W]),
            .rd_en_a  (rd_en_a),
            .rd_idx_a (cpu_idx),
            .rd_en_b  (rd_en_b),
            .rd_idx_b (vid_idx),
            .dout_a   (lane_a_word[i*LANE_W +: LANE_W]),
            .dout_b   (lane_b_word[i*LANE_W +: LANE_W])
        );
    end

    // The zero flags mask bank outputs that are stale, out of range or from before the sweep.
    always_comb begin
        rvalid_d    = cpu_acc & ~we;
        err_d       = cpu_acc & cpu_oor;
        rd_zero_d   = rd_zero_q;
        vid_valid_d = vid_req;
        vid_zero_d  = vid_zero_q;
        if (cpu_acc && !we) begin
            rd_zero_d = cpu_oor;
        end
        if (vid_req) begin
            vid_zero_d = ~ready | vid_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rd_zero_q   <= 1'b1;
            vid_valid_q <= 1'b0;
            vid_zero_q  <= 1'b1;
        end else begin
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rd_zero_q   <= rd_zero_d;
            vid_valid_q <= vid_valid_d;
            vid_zero_q  <= vid_zero_d;
        end
    end

`ifdef RAM_WR_BYPASS_EN
    logic              byp_q, byp_d;
    logic [LANES-1:0]  byp_sel_q, byp_sel_d;
    logic [DATA_W-1:0] byp_wdata_q, byp_wdata_d;

    // Capture the colliding write so its lanes can be merged over the old bank data.
    always_comb begin
        byp_d       = byp_q;
        byp_sel_d   = byp_sel_q;
        byp_wdata_d = byp_wdata_q;
        if (vid_req) begin
            byp_d       = cpu_acc & we & ~cpu_oor & ~vid_oor & (cpu_idx == vid_idx);
            byp_sel_d   = sel;
            byp_wdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q       <= 1'b0;
            byp_sel_q   <= '0;
            byp_wdata_q <= '0;
        end else begin
            byp_q       <= byp_d;
            byp_sel_q   <= byp_sel_d;
            byp_wdata_q <= byp_wdata_d;
        end
    end

    always_comb begin
        vid_word = lane_b_word;
        if (byp_q) begin
            for (int i = 0; i < LANES; i++) begin
                vid_word[i*LANE_W +: LANE_W] = lane_merge(lane_b_word[i*LANE_W +: LANE_W],
                                                          byp_wdata_q[i*LANE_W +: LANE_W],
                                                          byp_sel_q[i]);
            end
        end
    end
`else
    assign vid_word = lane_b_word;
`endif

    assign rdata     = rd_zero_q ? '0 : lane_a_word;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign vid_rdata = vid_zero_q ? '0 : vid_word;
    assign vid_valid = vid_valid_q;

endmodule

// File: tb/tb_ram_banked_dp.sv
// Randomised bench for ram_banked_dp against a word-array reference model.
module tb_ram_banked_dp;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 32;
    localparam int LANES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_valid;

    always #5 clk = ~clk;

    ram_banked_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .sel       (sel),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .err       (err),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .vid_valid (vid_valid)
    );

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_rdata;
    logic [DATA_W-1:0] exp_vid;
    int checks   = 0;
    int failures = 0;

    // Counts a comparison and reports it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit outOfRange(input logic [ADDR_W-1:0] a);
        return a >= ADDR_W'(DEPTH * 4);
    endfunction

    function automatic int wordOf(input logic [ADDR_W-1:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] mergeWord(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [LANES-1:0]  s);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int l = 0; l < LANES; l++) begin
            if (s[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return r;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_rdata = '0;
        exp_vid   = '0;
    endtask

    // One RUN-mode cycle: drive a request, predict the response, check it after the edge.
    task automatic applyStimulus(input bit i_en, input bit i_we, input logic [31:0] i_addr,
                                 input logic [3:0] i_sel, input logic [31:0] i_wdata,
                                 input bit i_vreq, input logic [31:0] i_vaddr);
        bit                exp_rvalid;
        bit                exp_err;
        bit                coll;
        logic [DATA_W-1:0] old_v;
        en = i_en; we = i_we; addr = i_addr; sel = i_sel; wdata = i_wdata;
        vid_req = i_vreq; vid_addr = i_vaddr;
        exp_rvalid = i_en && !i_we;
        exp_err    = i_en && outOfRange(i_addr);
        if (exp_rvalid) exp_rdata = outOfRange(i_addr) ? '0 : model_mem[wordOf(i_addr)];
        if (i_vreq) begin
            coll  = i_en && i_we && !outOfRange(i_addr) && !outOfRange(i_vaddr)
                    && (wordOf(i_addr) == wordOf(i_vaddr));
            old_v = model_mem[wordOf(i_vaddr)];
`ifdef RAM_WR_BYPASS_EN
            if (coll) old_v = mergeWord(old_v, i_wdata, i_sel);
`else
            coll = 1'b0;
`endif
            exp_vid = outOfRange(i_vaddr) ? '0 : old_v;
        end
        if (i_en && i_we && !outOfRange(i_addr))
            model_mem[wordOf(i_addr)] = mergeWord(model_mem[wordOf(i_addr)], i_wdata, i_sel);
        @(posedge clk);
        #1;
        checkOutput("ready",     32'(ready),     32'd1);
        checkOutput("rvalid",    32'(rvalid),    32'(exp_rvalid));
        checkOutput("err",       32'(err),       32'(exp_err));
        checkOutput("rdata",     rdata,          exp_rdata);
        checkOutput("vid_valid", 32'(vid_valid), 32'(i_vreq));
        checkOutput("vid_rdata", vid_rdata,      exp_vid);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Pulse reset, check the cleared outputs, then time the sweep while poking both ports.
    task automatic doReset();
        int n;
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        @(posedge clk);
        #1;
        checkOutput("rst_ready",     32'(ready),     32'd0);
        checkOutput("rst_rdata",     rdata,          32'd0);
        checkOutput("rst_rvalid",    32'(rvalid),    32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_vid_rdata", vid_rdata,      32'd0);
        checkOutput("rst_vid_valid", 32'(vid_valid), 32'd0);
        rst = 1'b0;
        resetModel();
        n = 0;
        while (!ready && n < 3 * DEPTH) begin
            en = 1'b1; we = 1'($urandom_range(0, 1)); sel = '1; wdata = $urandom;
            addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            vid_req = 1'b1; vid_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            @(posedge clk);
            #1;
            n++;
            if (n % 256 == 0) begin
                checkOutput("init_rvalid",    32'(rvalid),    32'd0);
                checkOutput("init_err",       32'(err),       32'd0);
                checkOutput("init_vid_valid", 32'(vid_valid), 32'd1);
                checkOutput("init_vid_rdata", vid_rdata,      32'd0);
            end
        end
        en = 1'b0; vid_req = 1'b0;
        checkOutput("ready_latency", 32'(n), 32'(DEPTH));
        if (!ready) begin
            $display("[TB] FAIL ready_timeout got=0 expected=1");
            $fatal(1, "[TB] ready never rose");
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] va;
        $display("[TB] start");
        doReset();

        for (int i = 0; i < 24; i++) begin
            ra = 32'($urandom_range(0, DEPTH - 1) * 4);
            applyStimulus(1, 0, ra, 0, 0, 1, 32'($urandom_range(0, DEPTH - 1) * 4));
            checkOutput("sweep_zero", rdata, 32'd0);
        end

        applyStimulus(1, 1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 0);
        applyStimulus(1, 1, 32'h10, 4'b0010, 32'h0000AA00, 0, 0);
        applyStimulus(1, 0, 32'h10, 4'b0000, 32'h0, 0, 0);
        checkOutput("merge_rdata", rdata, 32'hDEADAAEF);
        idle(1);
        checkOutput("rvalid_single", 32'(rvalid), 32'd0);

        applyStimulus(1, 1, 32'h4, 4'b1111, 32'h44444444, 0, 0);
        applyStimulus(1, 1, 32'h8, 4'b1111, 32'h88888888, 0, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0);
        checkOutput("b2b_0", rdata, 32'h0);
        applyStimulus(1, 0, 32'h4, 0, 0, 0, 0);
        checkOutput("b2b_4", rdata, 32'h44444444);
        applyStimulus(1, 0, 32'h8, 0, 0, 0, 0);
        checkOutput("b2b_8", rdata, 32'h88888888);

        applyStimulus(1, 0, 32'h2000, 0, 0, 0, 0);
        checkOutput("oor_rd_err", 32'(err), 32'd1);
        checkOutput("oor_rd_data", rdata, 32'd0);
        applyStimulus(1, 1, 32'h2000, 4'b1111, 32'hCAFEF00D, 0, 0);
        checkOutput("oor_wr_err", 32'(err), 32'd1);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0);
        checkOutput("oor_word0", rdata, 32'h0);

        applyStimulus(1, 1, 32'h40, 4'b1111, 32'h11223344, 1, 32'h40);
`ifdef RAM_WR_BYPASS_EN
        checkOutput("collision_vid", vid_rdata, 32'h11223344);
`else
        checkOutput("collision_vid", vid_rdata, 32'h00000000);
`endif
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h43);
        checkOutput("vid_after", vid_rdata, 32'h11223344);

        for (int i = 0; i < 600; i++) begin
            ra = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ra = $urandom | 32'h0000_2000;
            va = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 15) == 0) va = $urandom | 32'h0000_2000;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                          4'($urandom), $urandom, 1'($urandom_range(0, 1)), va);
        end

        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0);
        doReset();
        applyStimulus(1, 0, 32'h10, 0, 0, 1, 32'h40);
        checkOutput("post_rst_10", rdata, 32'h0);
        checkOutput("post_rst_40", vid_rdata, 32'h0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
